mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
// - Data-memory bus master for the MEM stage. Turns one load/store request into one Avalon-style
//   read/write with waitrequest, and stalls the pipeline while the access is outstanding.
// - Drives a word-aligned address, byte enables and lane-replicated write data.
// - Captures the raw 32-bit read word and its byte offset and hands both to the downstream
//   load selector, which does sign/zero extension and lane extraction.
// PARAMETERS
// - TIMEOUT_CYCLES  default 64  maximum waitrequest-high cycles in REQ before the access is
//                               abandoned; 0 disables the timeout
// PORTS
// - clk              in   1   rising-edge clock
// - reset            in   1   synchronous, active-high reset
// - req_valid        in   1   MEM stage holds a load/store; must stay stable while stall=1
// - req_write        in   1   1 = store, 0 = load
// - req_size         in   2   00 = byte, 01 = half, 10 = word; 11 is treated as word
// - req_addr         in   32  byte address
// - req_wdata        in   32  store data, right-justified
// - stall            out  1   freeze the pipeline
// - rdata            out  32  raw bus word for the load selector
// - rdata_valid      out  1   one-cycle pulse: the access completed; rdata is valid on loads
// - byte_off         out  2   latched req_addr[1:0] for the load selector
// - timeout_err      out  1   sticky; cleared only by reset
// - avm_address      out  32  {addr[31:2],2'b00}
// - avm_read         out  1   read strobe
// - avm_write        out  1   write strobe
// - avm_byteenable   out  4   active byte lanes
// - avm_writedata    out  32  lane-replicated store data
// - avm_readdata     in   32  read return, sampled on the cycle waitrequest=0
// - avm_waitrequest  in   1   slave not ready
// BEHAVIOUR
// - Reset: state IDLE, timeout counter 0. Outputs: avm_read=0, avm_write=0, avm_byteenable=0,
//   avm_address=0, avm_writedata=0, rdata=0, rdata_valid=0, byte_off=0, timeout_err=0.
// - Reset asserted mid-access: strobes drop at that edge, state goes to IDLE, no rdata_valid pulse.
// - stall = (state==IDLE && req_valid) || state==REQ. stall is 0 in DONE.
// - FSM, three states:
//   - IDLE -> REQ when req_valid. Latch addr, size, write and data. Register the bus outputs so
//     the strobe is visible in the first REQ cycle.
//   - REQ: hold every bus output stable while avm_waitrequest=1 and count those cycles.
//     - waitrequest=0: drop the strobe at the next edge, capture avm_readdata into rdata
//       (loads only; stores leave rdata unchanged), go to DONE.
//     - Counter reaches TIMEOUT_CYCLES (when nonzero): drop the strobe, set rdata=0, set
//       timeout_err, go to DONE.
//   - DONE: rdata_valid=1 for exactly one cycle, stall=0 so the pipeline advances, then IDLE.
//     Any req_valid seen in DONE is ignored.
// - Minimum latency: 3 cycles from acceptance to rdata_valid (IDLE, REQ with waitrequest=0, DONE).
// - Byte enables by size:
//   - byte: 4'b0001 << addr[1:0]
//   - half: addr[1] ? 4'b1100 : 4'b0011
//   - word: 4'b1111
// - Write data by size: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
// - avm_read and avm_write are never high together. The counter clears on every REQ entry.
// CONFIGURATION
// - MEM_ACCESS_ALIGN_CHECK_EN defined:
//   - Adds output addr_err (1 bit).
//   - A half with addr[0]=1, or a word with addr[1:0]!=0, issues no bus cycle: IDLE -> DONE
//     directly, rdata=0, and addr_err pulses together with rdata_valid.
// - MEM_ACCESS_ALIGN_CHECK_EN not defined:
//   - No addr_err port.
//   - Offset bits below the access size are ignored (half uses addr[1] only; word ignores both).
// TESTING
// - Word load at 0x100, waitrequest=0, readdata=0xDEADBEEF -> read held 1 cycle,
//   address 0x100, byteenable 1111; rdata_valid on cycle 3 with rdata=0xDEADBEEF.
// - Byte store at 0x203, wdata=0x000000A5 -> address 0x200, byteenable 1000,
//   writedata 0xA5A5A5A5, rdata_valid pulse.
// - Half load at 0x42 with waitrequest high 5 cycles -> address/read/byteenable 1100 stable
//   throughout; stall=1 for 6 cycles; byte_off=2.
// - TIMEOUT_CYCLES=4, waitrequest stuck high -> strobe dropped after 4 cycles, rdata=0,
//   timeout_err stays 1 until reset.
// - Reset on the second REQ cycle -> read=0, stall=0 next cycle, no rdata_valid.
// - With MEM_ACCESS_ALIGN_CHECK_EN, word load at 0x101 -> no strobe, addr_err and
//   rdata_valid pulse together.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data bus master (Avalon-style, waitrequest).
// Optional: MEM_ACCESS_ALIGN_CHECK_EN adds addr_err and misaligned-access trapping.
module mem_access_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        stall,
   output logic [31:0] rdata,
   output logic        rdata_valid,
   output logic [1:0]  byte_off,
   output logic        timeout_err,
   output logic [31:0] avm_address,
   output logic        avm_read,
   output logic        avm_write,
   output logic [3:0]  avm_byteenable,
   output logic [31:0] avm_writedata,
   input  logic [31:0] avm_readdata,
   input  logic        avm_waitrequest
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
   ,
   output logic        addr_err
`endif
);

   localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
   localparam logic [CW-1:0] CNT_LAST =
      CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_DONE
   } state_e;

   state_e         state_q;
   logic [CW-1:0]  cnt_q;
   logic [31:0]    addr_q;
   logic           rd_q;
   logic           wr_q;
   logic [3:0]     be_q;
   logic [31:0]    wd_q;
   logic [31:0]    rdata_q;
   logic           rvalid_q;
   logic [1:0]     off_q;
   logic           terr_q;
   logic [3:0]     be_d;
   logic [31:0]    wd_d;
   logic           misal;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
   logic           aerr_q;
`endif

   // Lane enables and replicated store data for the incoming request
   always_comb begin
      be_d = 4'b1111;
      wd_d = req_wdata;
      case (req_size)
         2'b00: begin
            be_d = 4'b0001 << req_addr[1:0];
            wd_d = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            be_d = req_addr[1] ? 4'b1100 : 4'b0011;
            wd_d = {2{req_wdata[15:0]}};
         end
         default: begin
            be_d = 4'b1111;
            wd_d = req_wdata;
         end
      endcase
   end

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
   assign misal = ((req_size == 2'b01) && req_addr[0]) ||
                  (req_size[1] && (req_addr[1:0] != 2'b00));
`else
   assign misal = 1'b0;
`endif

   // Access FSM with all bus and result outputs registered
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         addr_q   <= '0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         be_q     <= '0;
         wd_q     <= '0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
         off_q    <= '0;
         terr_q   <= 1'b0;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
         aerr_q   <= 1'b0;
`endif
      end else begin
         rvalid_q <= 1'b0;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
         aerr_q   <= 1'b0;
`endif
         unique case (state_q)
            S_IDLE: begin
               if (req_valid) begin
                  off_q <= req_addr[1:0];
                  cnt_q <= '0;
                  if (misal) begin
                     rdata_q  <= '0;
                     rvalid_q <= 1'b1;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
                     aerr_q   <= 1'b1;
`endif
                     state_q  <= S_DONE;
                  end else begin
                     addr_q  <= {req_addr[31:2], 2'b00};
                     be_q    <= be_d;
                     wd_q    <= wd_d;
                     rd_q    <= ~req_write;
                     wr_q    <= req_write;
                     state_q <= S_REQ;
                  end
               end
            end
            S_REQ: begin
               if (!avm_waitrequest) begin
                  rd_q     <= 1'b0;
                  wr_q     <= 1'b0;
                  if (rd_q) begin
                     rdata_q <= avm_readdata;
                  end
                  rvalid_q <= 1'b1;
                  state_q  <= S_DONE;
               end else if (TO_EN && (cnt_q == CNT_LAST)) begin
                  rd_q     <= 1'b0;
                  wr_q     <= 1'b0;
                  rdata_q  <= '0;
                  terr_q   <= 1'b1;
                  rvalid_q <= 1'b1;
                  state_q  <= S_DONE;
               end else if (TO_EN) begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign stall          = ((state_q == S_IDLE) && req_valid) || (state_q == S_REQ);
   assign rdata          = rdata_q;
   assign rdata_valid    = rvalid_q;
   assign byte_off       = off_q;
   assign timeout_err    = terr_q;
   assign avm_address    = addr_q;
   assign avm_read       = rd_q;
   assign avm_write      = wr_q;
   assign avm_byteenable = be_q;
   assign avm_writedata  = wd_q;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
   assign addr_err       = aerr_q;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed + random accesses against a transaction model.
// Instance u_b runs with TIMEOUT_CYCLES=4 for the timeout scenario.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_valid_b, req_write;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata, avm_readdata;
   logic        wr_a, wr_b;

   logic        stall, rdata_valid, timeout_err, avm_read, avm_write;
   logic [31:0] rdata, avm_address, avm_writedata;
   logic [1:0]  byte_off;
   logic [3:0]  avm_byteenable;

   logic        stall_b, rdata_valid_b, timeout_err_b, avm_read_b, avm_write_b;
   logic [31:0] rdata_b, avm_address_b, avm_writedata_b;
   logic [1:0]  byte_off_b;
   logic [3:0]  avm_byteenable_b;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
   logic        addr_err, addr_err_b;
`endif

   int          n_chk = 0;
   int          n_fail = 0;
   logic [31:0] m_rdata;

   always #5 clk = ~clk;

   mem_access_unit u_a (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
      .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
      .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid),
      .byte_off(byte_off), .timeout_err(timeout_err),
      .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
      .avm_byteenable(avm_byteenable), .avm_writedata(avm_writedata),
      .avm_readdata(avm_readdata), .avm_waitrequest(wr_a)
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
      , .addr_err(addr_err)
`endif
   );

   mem_access_unit #(.TIMEOUT_CYCLES(4)) u_b (
      .clk(clk), .reset(reset), .req_valid(req_valid_b), .req_write(req_write),
      .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
      .stall(stall_b), .rdata(rdata_b), .rdata_valid(rdata_valid_b),
      .byte_off(byte_off_b), .timeout_err(timeout_err_b),
      .avm_address(avm_address_b), .avm_read(avm_read_b), .avm_write(avm_write_b),
      .avm_byteenable(avm_byteenable_b), .avm_writedata(avm_writedata_b),
      .avm_readdata(avm_readdata), .avm_waitrequest(wr_b)
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
      , .addr_err(addr_err_b)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] exp_be(input logic [1:0] sz, input logic [31:0] a);
      int off;
      off = int'(a % 4);
      if (sz == 2'd0) return 4'(1 << off);
      if (sz == 2'd1) return (off >= 2) ? 4'd12 : 4'd3;
      return 4'd15;
   endfunction

   function automatic logic [31:0] exp_wd(input logic [1:0] sz, input logic [31:0] w);
      if (sz == 2'd0) return (w & 32'hFF) * 32'h01010101;
      if (sz == 2'd1) return (w & 32'hFFFF) * 32'h00010001;
      return w;
   endfunction

   function automatic bit misaligned(input logic [1:0] sz, input logic [31:0] a);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
      if (sz == 2'd1) return (a % 2) != 0;
      if (sz >= 2'd2) return (a % 4) != 0;
      return 1'b0;
`else
      return 1'b0;
`endif
   endfunction

   // One access on u_a; waitrequest is high for nwait cycles counted from acceptance
   task automatic txn(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                      input logic [31:0] wd, input int nwait, input logic [31:0] rd);
      int  stalls;
      int  exp_req;
      bit  done;
      bit  mis;
      @(negedge clk);
      req_valid    = 1'b1;
      req_write    = wr;
      req_size     = sz;
      req_addr     = a;
      req_wdata    = wd;
      wr_a         = (nwait > 0);
      avm_readdata = $urandom;
      #1;
      check("stall_accept", stall, 1);
      stalls  = 1;
      mis     = misaligned(sz, a);
      exp_req = mis ? 0 : ((nwait > 1) ? nwait : 1);
      done    = 0;
      for (int k = 1; k <= 20 && !done; k++) begin
         @(negedge clk);
         wr_a         = (k < nwait);
         avm_readdata = (k < nwait) ? $urandom : rd;
         #1;
         if (rdata_valid === 1'b1) begin
            done = 1;
            if (mis) m_rdata = 32'd0;
            else if (!wr) m_rdata = rd;
            check("latency", k, exp_req + 1);
            check("stall_cycles", stalls, exp_req + 1);
            check("stall_done", stall, 0);
            check("strobe_done", {avm_read, avm_write}, 0);
            check("rdata", rdata, m_rdata);
            check("byte_off", byte_off, a[1:0]);
            check("timeout_err", timeout_err, 0);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
            check("addr_err", addr_err, mis);
`endif
         end else begin
            if (stall) stalls++;
            check("req_stall", stall, 1);
            check("req_read", avm_read, !wr);
            check("req_write", avm_write, wr);
            check("req_addr", avm_address, a & ~32'd3);
            check("req_be", avm_byteenable, exp_be(sz, a));
            check("req_wdata", avm_writedata, exp_wd(sz, wd));
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
            check("req_addr_err", addr_err, 0);
`endif
         end
      end
      check("completion", done, 1);
      @(negedge clk);
      req_valid = 1'b0;
      wr_a      = 1'b0;
      #1;
      check("idle_strobe", {avm_read, avm_write}, 0);
      check("idle_valid", rdata_valid, 0);
      check("idle_stall", stall, 0);
   endtask

   initial begin
      int  reads;
      bit  done;
      reset        = 1'b1;
      req_valid    = 1'b0;
      req_valid_b  = 1'b0;
      req_write    = 1'b0;
      req_size     = 2'd0;
      req_addr     = '0;
      req_wdata    = '0;
      avm_readdata = '0;
      wr_a         = 1'b0;
      wr_b         = 1'b0;
      m_rdata      = '0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_read", avm_read, 0);
      check("rst_write", avm_write, 0);
      check("rst_be", avm_byteenable, 0);
      check("rst_addr", avm_address, 0);
      check("rst_wdata", avm_writedata, 0);
      check("rst_rdata", rdata, 0);
      check("rst_valid", rdata_valid, 0);
      check("rst_off", byte_off, 0);
      check("rst_terr", timeout_err, 0);
      check("rst_stall", stall, 0);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
      check("rst_aerr", addr_err, 0);
`endif
      reset = 1'b0;

      txn(1'b0, 2'd2, 32'h0000_0100, 32'h0, 0, 32'hDEAD_BEEF);
      txn(1'b1, 2'd0, 32'h0000_0203, 32'h0000_00A5, 0, 32'h1234_5678);
      txn(1'b0, 2'd1, 32'h0000_0042, 32'h0, 5, 32'hCAFE_F00D);
      txn(1'b0, 2'd3, 32'h0000_0104, 32'h0, 2, 32'h0BAD_CAFE);
      txn(1'b0, 2'd2, 32'h0000_0101, 32'h0, 0, 32'h5555_AAAA);
      txn(1'b1, 2'd1, 32'h0000_0011, 32'hFFFF_8001, 1, 32'h0);

      for (int i = 0; i < 40; i++) begin
         txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom,
             $urandom, $urandom_range(0, 4), $urandom);
      end

      // Timeout on the 4-cycle instance with waitrequest stuck high
      @(negedge clk);
      req_valid_b = 1'b1;
      req_write   = 1'b0;
      req_size    = 2'd2;
      req_addr    = 32'h0000_0300;
      wr_b        = 1'b1;
      reads       = 0;
      done        = 0;
      for (int k = 1; k <= 12 && !done; k++) begin
         @(negedge clk);
         avm_readdata = $urandom;
         #1;
         if (rdata_valid_b === 1'b1) begin
            done = 1;
            check("to_strobe_cycles", reads, 4);
            check("to_rdata", rdata_b, 0);
            check("to_err", timeout_err_b, 1);
            check("to_read_dropped", avm_read_b, 0);
         end else if (avm_read_b) begin
            reads++;
         end
      end
      check("to_completion", done, 1);
      @(negedge clk);
      req_valid_b = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("to_sticky", timeout_err_b, 1);
      check("to_idle_read", avm_read_b, 0);
      wr_b = 1'b0;

      // Reset on the second REQ cycle of a load
      @(negedge clk);
      req_valid = 1'b1;
      req_write = 1'b0;
      req_size  = 2'd2;
      req_addr  = 32'h0000_0080;
      wr_a      = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #1;
      check("mid_read", avm_read, 1);
      reset     = 1'b1;
      req_valid = 1'b0;
      @(negedge clk);
      #1;
      check("mid_rst_read", avm_read, 0);
      check("mid_rst_stall", stall, 0);
      check("mid_rst_valid", rdata_valid, 0);
      check("mid_rst_terr_b", timeout_err_b, 0);
      reset   = 1'b0;
      wr_a    = 1'b0;
      m_rdata = 32'd0;
      @(negedge clk);
      #1;
      check("post_rst_valid", rdata_valid, 0);
      check("post_rst_read", avm_read, 0);

      txn(1'b0, 2'd0, 32'h0000_0403, 32'h0, 1, 32'h8877_6655);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
